// File: rtl/regfile_mp.sv
// Purpose : multi-port register file, 1 write + 2 registered reads, with a sequential clear sweep.
// Latency : reads 1 cycle (address sampled at elk edge, data valid after it); writes land at the edge.
// Backpres: writes arriving while busy are dropped and flagged by a one-cycle wr_drop pulse.
//
// Ports:
//   elk, rst               clock (rising edge) and synchronous active-high reset
//   wr_en/wr_addr/wr_data  write request
//   rd_addrA/rd_addrB      read addresses; rd_dataA/rd_dataB registered read data
//   clr_start              starts a DEPTH-cycle sweep that zeroes every register
//   busy                   high while the sweep runs
//   wr_drop                pulses the cycle after a write was rejected because of busy
//
// Optional feature: define REGFILE_MP_BYPASS_EN to forward an accepted write to a read
// port reading the same address in the same cycle. Without it the pre-write value is read.
module regfile_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1
) (
  input  logic              elk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addrA,
  input  logic [ADDR_W-1:0] rd_addrB,
  input  logic              clr_start,
  output logic [DATA_W-1:0] rd_dataA,
  output logic [DATA_W-1:0] rd_dataB,
  output logic              busy,
  output logic              wr_drop
);

  localparam int DEPTH = 2**ADDR_W;

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] ptr;
  logic [ADDR_W-1:0] ptr_nxt;
  logic [DATA_W-1:0] mem [DEPTH];

  logic              wr_zero;
  logic              wr_acc;
  logic [DATA_W-1:0] rd_nxt_a;
  logic [DATA_W-1:0] rd_nxt_b;

  // busy comes straight from the state flop, so clr_start never reaches it combinationally.
  assign busy = (state == CLEAR);

  // Writes to the hard-wired zero register are swallowed without a drop indication.
  assign wr_zero = (ZERO_REG != 0) && (wr_addr == '0);
  assign wr_acc  = wr_en && !busy && !wr_zero;

  // Next-state logic: clr_start only matters in IDLE, so a running sweep is never restarted.
  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    case (state)
      IDLE: begin
        if (clr_start) begin
          state_nxt = CLEAR;
          ptr_nxt   = '0;
        end
      end
      CLEAR: begin
        ptr_nxt = ptr + 1'b1;
        if (ptr == {ADDR_W{1'b1}}) begin
          state_nxt = IDLE;
          ptr_nxt   = '0;
        end
      end
      default: begin
        state_nxt = IDLE;
        ptr_nxt   = '0;
      end
    endcase
  end

  // Read data for the next cycle. The sweep is never bypassed: a read of the address being
  // cleared this cycle still returns the old contents.
  always_comb begin
    rd_nxt_a = mem[rd_addrA];
    rd_nxt_b = mem[rd_addrB];
    if ((ZERO_REG != 0) && (rd_addrA == '0)) rd_nxt_a = '0;
    if ((ZERO_REG != 0) && (rd_addrB == '0)) rd_nxt_b = '0;
`ifdef REGFILE_MP_BYPASS_EN
    // wr_acc already excludes rejected writes and zero-register writes.
    if (wr_acc && (wr_addr == rd_addrA)) rd_nxt_a = wr_data;
    if (wr_acc && (wr_addr == rd_addrB)) rd_nxt_b = wr_data;
`endif
  end

  always_ff @(posedge elk) begin
    if (rst) begin
      state    <= IDLE;
      ptr      <= '0;
      wr_drop  <= 1'b0;
      rd_dataA <= '0;
      rd_dataB <= '0;
    end else begin
      state    <= state_nxt;
      ptr      <= ptr_nxt;
      wr_drop  <= wr_en && busy;
      rd_dataA <= rd_nxt_a;
      rd_dataB <= rd_nxt_b;
    end
  end

  // Array storage. Accepted writes and sweep clears never coincide because writes are
  // only accepted while not busy.
  always_ff @(posedge elk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (wr_acc) mem[wr_addr] <= wr_data;
      if (busy)   mem[ptr]     <= '0;
    end
  end

endmodule
